// File: rtl/mcp_pkg.sv
// Shared definitions for the MCP-formulation CDC handshake: state encoding,
// synchronizer default depth and busy-counter geometry.
package mcp_pkg;

    typedef enum logic {
        MCP_READY = 1'b0,
        MCP_BUSY  = 1'b1
    } mcp_state_e;

    localparam int MCP_SYNC_STAGES_DEF = 2;
    localparam int MCP_CNT_W           = 8;
    localparam logic [MCP_CNT_W-1:0] MCP_CNT_MAX = 8'hFF;

    // Compare value for the busy counter; a zero timeout means the check is off.
    function automatic logic [MCP_CNT_W-1:0] mcp_timeout_cmp(input int timeout);
        if (timeout > 0) begin
            return MCP_CNT_W'(timeout - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mcp_src_ctrl_if.sv
// Source-side bus of the MCP CDC handshake, grouping request, held data,
// the cross-domain toggles and the sticky error flags.
interface mcp_src_ctrl_if #(
    parameter int DATA_W = 8
);
    // Handshake: asend is valid, aready is ready. A word transfers on the clk_a
    // edge where both are 1; asend while aready=0 is dropped and flagged as overrun.
    logic              asend;
    logic [DATA_W-1:0] adata;
    logic              aready;
    logic              a_en_tog;
    logic [DATA_W-1:0] adata_hold;
    logic              b_ack_tog;
    logic              overrun;
    logic              timeout;
    logic              err_clr;

    modport master (
        output asend, adata, b_ack_tog, err_clr,
        input  aready, a_en_tog, adata_hold, overrun, timeout
    );

    modport slave (
        input  asend, adata, b_ack_tog, err_clr,
        output aready, a_en_tog, adata_hold, overrun, timeout
    );

endinterface

// File: rtl/mcp_tog_sync.sv
// Toggle synchronizer: SYNC_STAGES flops plus an edge register, producing a
// one-cycle pulse per toggle of the asynchronous input.
module mcp_tog_sync
    import mcp_pkg::*;
#(
    parameter int SYNC_STAGES = MCP_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic tog_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] ^ edge_q;

endmodule

// File: rtl/mcp_src_ctrl.sv
// Source half of the MCP CDC handshake: captures a word, flips the load toggle,
// waits for the synchronized ack toggle, and tracks overrun/timeout errors.
module mcp_src_ctrl
    import mcp_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = MCP_SYNC_STAGES_DEF,
    parameter int TIMEOUT     = 0
) (
    input  logic           clk_a,
    input  logic           rstn_a,
    mcp_src_ctrl_if.slave  bus,
    output mcp_state_e     dbg_state
);

    localparam bit                   TO_EN  = (TIMEOUT != 0);
    localparam logic [MCP_CNT_W-1:0] TO_CMP = mcp_timeout_cmp(TIMEOUT);

    mcp_state_e           state_q;
    mcp_state_e           state_d;
    logic                 ack_pulse;
    logic                 accept;
    logic                 ovr_set;
    logic                 in_busy;
    logic                 aready_c;
    logic                 to_hit;
    logic                 tog_q;
    logic [DATA_W-1:0]    hold_q;
    logic [MCP_CNT_W-1:0] cnt_q;
    logic                 ovr_q;
    logic                 to_q;

    mcp_tog_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk    (clk_a),
        .rstn   (rstn_a),
        .tog_in (bus.b_ack_tog),
        .pulse  (ack_pulse)
    );

    always_ff @(posedge clk_a or negedge rstn_a) begin
        if (!rstn_a) begin
            state_q <= MCP_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack arriving while READY is a stray toggle and has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MCP_READY: if (bus.asend) state_d = MCP_BUSY;
            MCP_BUSY:  if (ack_pulse) state_d = MCP_READY;
            default:   state_d = MCP_READY;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        ovr_set  = 1'b0;
        in_busy  = 1'b0;
        aready_c = 1'b0;
        case (state_q)
            MCP_READY: begin
                aready_c = 1'b1;
                accept   = bus.asend;
            end
            MCP_BUSY: begin
                in_busy = 1'b1;
                ovr_set = bus.asend;
            end
            default: aready_c = 1'b1;
        endcase
    end

    assign to_hit = TO_EN && in_busy && (cnt_q == TO_CMP);

    always_ff @(posedge clk_a or negedge rstn_a) begin
        if (!rstn_a) begin
            tog_q  <= 1'b0;
            hold_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            tog_q  <= ~tog_q;
            hold_q <= bus.adata;
            cnt_q  <= '0;
        end else if (in_busy && cnt_q != MCP_CNT_MAX) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Set events take priority over a clear in the same cycle.
    always_ff @(posedge clk_a or negedge rstn_a) begin
        if (!rstn_a) begin
            ovr_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovr_q <= 1'b0;
            end
            if (to_hit) begin
                to_q <= 1'b1;
            end else if (bus.err_clr) begin
                to_q <= 1'b0;
            end
        end
    end

    assign bus.aready     = aready_c;
    assign bus.a_en_tog   = tog_q;
    assign bus.adata_hold = hold_q;
    assign bus.overrun    = ovr_q;
    assign bus.timeout    = to_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mcp_src_ctrl.sv
// Bench for mcp_src_ctrl: transaction-level model compared every cycle, plus
// directed checks with hand-computed values and a streaming run.
module tb_mcp_src_ctrl;
  import mcp_pkg::*;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 10;

  logic       clk_a  = 1'b0;
  logic       rstn_a = 1'b0;
  mcp_state_e dbg_state;

  mcp_src_ctrl_if #(.DATA_W(DW)) bus ();

  mcp_src_ctrl #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT     (TO)
  ) dut (
    .clk_a     (clk_a),
    .rstn_a    (rstn_a),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk_a = ~clk_a;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // model: ack toggles become pulses SS edges after they are first sampled
  bit          m_busy, m_tog, m_ovr, m_to, m_prev_b;
  logic [DW-1:0] m_hold;
  int          m_cyc = 0;
  int          m_busy_edges;
  int          m_ack_q[$];

  always @(posedge clk_a or negedge rstn_a) begin
    if (!rstn_a) begin
      m_busy = 0; m_tog = 0; m_ovr = 0; m_to = 0; m_prev_b = 0;
      m_hold = '0; m_busy_edges = 0;
      m_ack_q.delete();
    end else begin
      bit pulse, ovr_set, to_set;
      m_cyc++;
      pulse = 0;
      if (m_ack_q.size() > 0 && m_ack_q[0] == m_cyc) begin
        pulse = 1;
        void'(m_ack_q.pop_front());
      end
      if (bus.b_ack_tog !== m_prev_b) begin
        m_ack_q.push_back(m_cyc + SS);
        m_prev_b = bus.b_ack_tog;
      end
      ovr_set = 0;
      to_set  = 0;
      if (m_busy) begin
        ovr_set = bus.asend;
        m_busy_edges++;
        if (TO != 0 && m_busy_edges == TO) to_set = 1;
        if (pulse) m_busy = 0;
      end else if (bus.asend) begin
        m_busy = 1;
        m_hold = bus.adata;
        m_tog  = ~m_tog;
        m_busy_edges = 0;
      end
      if (bus.err_clr) begin m_ovr = 0; m_to = 0; end
      if (ovr_set) m_ovr = 1;
      if (to_set)  m_to  = 1;
    end
  end

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_a);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    bus.asend = 1'b1;
    bus.adata = d;
    step(1);
    bus.asend = 1'b0;
  endtask

  task automatic ack();
    bus.b_ack_tog = ~bus.b_ack_tog;
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
  endtask

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] words [16] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3,
                                8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  int flips;

  initial begin
    bus.asend = 1'b0; bus.adata = '0; bus.b_ack_tog = 1'b0; bus.err_clr = 1'b0;

    // scoreboard: every-cycle compare against the model
    fork
      forever begin
        @(negedge clk_a);
        if (chk_en) begin
          n_checks++;
          if ({bus.aready, bus.a_en_tog, bus.adata_hold, bus.overrun, bus.timeout,
               (dbg_state == MCP_BUSY)} !==
              {~m_busy, m_tog, m_hold, m_ovr, m_to, m_busy}) begin
            n_errors++;
            $display("FAIL cycle_cmp t=%0t: rdy/tog/hold/ovr/to/busy got %b/%b/%h/%b/%b/%b expected %b/%b/%h/%b/%b/%b",
                     $time, bus.aready, bus.a_en_tog, bus.adata_hold, bus.overrun, bus.timeout,
                     dbg_state == MCP_BUSY, ~m_busy, m_tog, m_hold, m_ovr, m_to, m_busy);
          end
        end
      end
    join_none

    // reset
    step(3);
    chk_en = 1'b1;
    check("rst_aready",  bus.aready,     1);
    check("rst_tog",     bus.a_en_tog,   0);
    check("rst_hold",    bus.adata_hold, 0);
    check("rst_overrun", bus.overrun,    0);
    check("rst_timeout", bus.timeout,    0);
    rstn_a = 1'b1;
    step(1);

    // single transfer
    send(8'hA5);
    check("acc_aready", bus.aready,     0);
    check("acc_tog",    bus.a_en_tog,   1);
    check("acc_hold",   bus.adata_hold, 8'hA5);
    ack();
    step(2);
    check("ack_e2_aready", bus.aready,     0);
    check("ack_e2_hold",   bus.adata_hold, 8'hA5);
    step(1);
    check("ack_e3_aready", bus.aready,     1);
    check("ack_e3_hold",   bus.adata_hold, 8'hA5);

    // overrun while busy, then asend on the ack edge
    send(8'h11);
    check("ovr_acc_tog", bus.a_en_tog, 0);
    bus.asend = 1'b1; bus.adata = 8'h3C;
    step(1);
    bus.asend = 1'b0;
    check("ovr_hold", bus.adata_hold, 8'h11);
    check("ovr_tog",  bus.a_en_tog,   0);
    check("ovr_flag", bus.overrun,    1);
    clear_err();
    check("ovr_clr", bus.overrun, 0);
    ack();
    step(2);
    bus.asend = 1'b1; bus.adata = 8'h3C;
    step(1);
    bus.asend = 1'b0;
    check("ovr_ack_aready", bus.aready,     1);
    check("ovr_ack_flag",   bus.overrun,    1);
    check("ovr_ack_tog",    bus.a_en_tog,   0);
    check("ovr_ack_hold",   bus.adata_hold, 8'h11);
    clear_err();

    // reset mid-busy, then a fresh transfer
    send(8'hFF);
    check("mid_acc_tog", bus.a_en_tog, 1);
    step(2);
    rstn_a = 1'b0;
    #1;
    check("mid_rst_aready", bus.aready,     1);
    check("mid_rst_tog",    bus.a_en_tog,   0);
    check("mid_rst_hold",   bus.adata_hold, 0);
    step(2);
    rstn_a = 1'b1;
    step(1);
    send(8'h99);
    check("fresh_tog",  bus.a_en_tog,   1);
    check("fresh_hold", bus.adata_hold, 8'h99);
    ack();
    step(3);
    check("fresh_aready", bus.aready, 1);

    // timeout after TO busy edges, recovery only by ack
    send(8'h5A);
    step(9);
    check("to_e9",  bus.timeout, 0);
    step(1);
    check("to_e10", bus.timeout, 1);
    check("to_e10_aready", bus.aready, 0);
    ack();
    step(3);
    check("to_ack_aready", bus.aready,  1);
    check("to_ack_flag",   bus.timeout, 1);
    clear_err();
    check("to_clr", bus.timeout, 0);

    // streaming with a destination model acking at random delays
    flips = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          int g;
          g = 0;
          while (!bus.aready && g < 50) begin step(1); g++; end
          if (g >= 50) check("stream_ready_wait", 0, 1);
          exp_q.push_back(words[i]);
          send(words[i]);
        end
      end
      begin
        logic last;
        int   budget;
        budget = 0;
        last = bus.a_en_tog;
        while (flips < 16 && budget < 2000) begin
          @(negedge clk_a);
          budget++;
          if (bus.a_en_tog !== last) begin
            last = bus.a_en_tog;
            flips++;
            if (exp_q.size() > 0) check("stream_word", bus.adata_hold, exp_q.pop_front());
            else check("stream_extra_flip", 1, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk_a);
            bus.b_ack_tog = ~bus.b_ack_tog;
          end
        end
      end
    join
    step(5);
    check("stream_flips",   flips,       16);
    check("stream_overrun", bus.overrun, 0);
    check("stream_aready",  bus.aready,  1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
